// File: rtl/ecc_burst_codec.sv
`timescale 1ns/1ps
// ecc_burst_codec: APB-programmed extended-Hamming (SECDED) encoder/decoder
// with an input FIFO and an optional noise-injection stage.
//
// Ports:
//   clk, rst                      - single clock, synchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA, PRDATA/PREADY/PSLVERR - APB slave
//   data_out, dout_valid, dout_ready - result word (zero-extended) + handshake
//   num_of_errors                 - 0 none, 1 corrected, 2 double detected
//   operation_done                - pulse on the cycle after the result handshake
//
// Register map (PADDR[4:2]): 0 CTRL, 1 DATA_IN, 2 CODEWORD_WIDTH, 3 NOISE,
// 4 STATUS = {overflow[8], busy[7], fifo_count[4:0]}.
//
// Build option: define ECC_NOISE_INJECT_EN to add the NOISE register and the
// NOISE state; without it modes 10/11 run ENC -> DEC directly.
module ecc_burst_codec #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [1:0]                 num_of_errors,
    output logic                       operation_done
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]            mode;
        logic [1:0]            width;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef struct packed {
        logic [1:0]            err;
        logic [DATA_WIDTH-1:0] data;
    } dec_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ENC   = 3'd2,
`ifdef ECC_NOISE_INJECT_EN
        S_NOISE = 3'd3,
`endif
        S_DEC   = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    function automatic logic is_parity_pos(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    // Unsupported or oversized width codes fall back to 8-bit codewords.
    function automatic logic [5:0] width_bits(input logic [1:0] code);
        logic [5:0] n;
        case (code)
            2'b01:   n = (DATA_WIDTH >= 16) ? 6'd16 : 6'd8;
            2'b10:   n = (DATA_WIDTH >= 32) ? 6'd32 : 6'd8;
            default: n = 6'd8;
        endcase
        return n;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] width_mask(input int n);
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < DATA_WIDTH; i++) m[i] = (i < n);
        return m;
    endfunction

    // Scatter data into non-power-of-2 slots, then fill Hamming parity and overall parity.
    function automatic logic [DATA_WIDTH-1:0] hamming_encode(input logic [DATA_WIDTH-1:0] data, input int n);
        logic [DATA_WIDTH-1:0] cw;
        logic [IW-1:0]         k;
        logic [4:0]            syn;
        cw  = '0;
        k   = '0;
        syn = 5'd0;
        for (int i = 1; i < DATA_WIDTH; i++) begin
            if (i < n && !is_parity_pos(i)) begin
                cw[i] = data[k];
                k     = k + IW'(1);
            end
        end
        for (int i = 1; i < DATA_WIDTH; i++) begin
            if (i < n && cw[i]) syn = syn ^ 5'(i);
        end
        // Parity slot 2^j takes syndrome bit j, driving the total syndrome to zero.
        for (int i = 1; i < DATA_WIDTH; i++) begin
            if (i < n && is_parity_pos(i)) cw[i] = |(syn & 5'(i));
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    // Grade the codeword, correct single errors, and gather the data slots.
    function automatic dec_t hamming_decode(input logic [DATA_WIDTH-1:0] cw, input int n);
        dec_t                  r;
        logic [DATA_WIDTH-1:0] fixed;
        logic [IW-1:0]         k;
        logic [4:0]            syn;
        logic                  par;
        syn   = 5'd0;
        par   = ^cw;
        fixed = cw;
        r     = '0;
        k     = '0;
        for (int i = 1; i < DATA_WIDTH; i++) begin
            if (i < n && cw[i]) syn = syn ^ 5'(i);
        end
        if (par) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (5'(i) == syn) fixed[i] = ~fixed[i];
            end
            r.err = 2'd1;
        end else if (syn != 5'd0) begin
            r.err = 2'd2;
        end else begin
            r.err = 2'd0;
        end
        for (int i = 1; i < DATA_WIDTH; i++) begin
            if (i < n && !is_parity_pos(i)) begin
                r.data[k] = fixed[i];
                k         = k + IW'(1);
            end
        end
        return r;
    endfunction

    state_t                state_r, state_next_s;
    entry_t                fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wptr_r, rptr_r;
    logic [4:0]            count_r;
    logic [1:0]            ctrl_r, cw_sel_r, mode_r, err_r;
    logic                  overflow_r, dout_valid_r, op_done_r;
    logic [5:0]            n_r;
    logic [DATA_WIDTH-1:0] cw_r, data_out_r;
    logic [AMBA_WORD-1:0]  prdata_r, rdata_s;
`ifdef ECC_NOISE_INJECT_EN
    logic [DATA_WIDTH-1:0] noise_r;
`endif

    logic       wr_s, rd_s, data_wr_s, full_s, pop_s, push_s, drop_s, busy_s, unused_s;
    logic [2:0] addr_s;
    entry_t     rd_entry_s, wr_entry_s;
    logic [5:0] load_n_s;
    logic [DATA_WIDTH-1:0] enc_s;
    dec_t       dec_s;

    assign addr_s     = PADDR[4:2];
    assign wr_s       = PSEL & PENABLE & PWRITE;
    assign rd_s       = PSEL & ~PWRITE;
    assign data_wr_s  = wr_s && (addr_s == 3'd1);
    assign full_s     = (count_r == 5'(FIFO_DEPTH));
    assign pop_s      = (state_r == S_LOAD);
    assign push_s     = data_wr_s && (!full_s || pop_s);
    assign drop_s     = data_wr_s && full_s && !pop_s;
    assign busy_s     = (state_r != S_IDLE);
    assign rd_entry_s = fifo_mem_r[rptr_r];
    assign wr_entry_s = {ctrl_r, cw_sel_r, PWDATA[DATA_WIDTH-1:0]};
    assign load_n_s   = width_bits(rd_entry_s.width);
    assign enc_s      = hamming_encode(cw_r, int'(n_r));
    assign dec_s      = hamming_decode(cw_r, int'(n_r));
    assign unused_s   = ^{PADDR, PWDATA};

    assign PREADY         = 1'b1;
    // The error must accompany the same access phase, so it cannot be registered.
    assign PSLVERR        = drop_s && !rst;
    assign PRDATA         = prdata_r;
    assign data_out       = data_out_r;
    assign dout_valid     = dout_valid_r;
    assign num_of_errors  = err_r;
    assign operation_done = op_done_r;

    // Register read mux.
    always_comb begin
        rdata_s = '0;
        case (addr_s)
            3'd0: rdata_s[1:0] = ctrl_r;
            3'd2: rdata_s[1:0] = cw_sel_r;
`ifdef ECC_NOISE_INJECT_EN
            3'd3: rdata_s[DATA_WIDTH-1:0] = noise_r;
`endif
            3'd4: begin
                rdata_s[8]   = overflow_r;
                rdata_s[7]   = busy_s;
                rdata_s[4:0] = count_r;
            end
            default: rdata_s = '0;
        endcase
    end

    // Configuration registers, sticky overflow and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r     <= 2'b00;
            cw_sel_r   <= 2'b00;
            overflow_r <= 1'b0;
            prdata_r   <= '0;
`ifdef ECC_NOISE_INJECT_EN
            noise_r    <= '0;
`endif
        end else begin
            if (wr_s && addr_s == 3'd0) begin
                ctrl_r <= PWDATA[1:0];
                if (PWDATA[31]) overflow_r <= 1'b0;
            end
            if (wr_s && addr_s == 3'd2) cw_sel_r <= PWDATA[1:0];
`ifdef ECC_NOISE_INJECT_EN
            if (wr_s && addr_s == 3'd3) noise_r <= PWDATA[DATA_WIDTH-1:0];
`endif
            if (drop_s) overflow_r <= 1'b1;
            if (rd_s) prdata_r <= rdata_s;
        end
    end

    // FIFO storage; each entry carries the mode and width captured at push time.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wptr_r] <= wr_entry_s;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= 5'd0;
        end else begin
            if (push_s) wptr_r <= wptr_r + AW'(1);
            if (pop_s)  rptr_r <= rptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_next_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (count_r != 5'd0) state_next_s = S_LOAD;
                else                 state_next_s = S_IDLE;
            end
            S_LOAD: begin
                if (rd_entry_s.mode == 2'b01) state_next_s = S_DEC;
                else                          state_next_s = S_ENC;
            end
            S_ENC: begin
                if (mode_r == 2'b00) state_next_s = S_OUT;
`ifdef ECC_NOISE_INJECT_EN
                else                 state_next_s = S_NOISE;
`else
                else                 state_next_s = S_DEC;
`endif
            end
`ifdef ECC_NOISE_INJECT_EN
            S_NOISE: state_next_s = S_DEC;
`endif
            S_DEC: state_next_s = S_OUT;
            S_OUT: begin
                if (dout_ready) state_next_s = S_IDLE;
                else            state_next_s = S_OUT;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath: load, encode, inject noise, decode, and hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cw_r         <= '0;
            mode_r       <= 2'b00;
            n_r          <= 6'd8;
            data_out_r   <= '0;
            err_r        <= 2'b00;
            dout_valid_r <= 1'b0;
            op_done_r    <= 1'b0;
        end else begin
            op_done_r <= (state_r == S_OUT) && dout_ready;
            case (state_r)
                S_LOAD: begin
                    cw_r   <= rd_entry_s.data & width_mask(int'(load_n_s));
                    mode_r <= rd_entry_s.mode;
                    n_r    <= load_n_s;
                end
                S_ENC: begin
                    cw_r <= enc_s;
                    if (mode_r == 2'b00) begin
                        data_out_r   <= enc_s;
                        err_r        <= 2'b00;
                        dout_valid_r <= 1'b1;
                    end
                end
`ifdef ECC_NOISE_INJECT_EN
                S_NOISE: cw_r <= cw_r ^ (noise_r & width_mask(int'(n_r)));
`endif
                S_DEC: begin
                    data_out_r   <= dec_s.data;
                    err_r        <= dec_s.err;
                    dout_valid_r <= 1'b1;
                end
                S_OUT: begin
                    if (dout_ready) dout_valid_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_burst_codec.sv
`timescale 1ns/1ps
// Directed bench for ecc_burst_codec: a vector table of single transactions
// plus hand-written sequences for overflow, simultaneous push/pop and reset.
module tb_ecc_burst_codec;

`ifdef ECC_NOISE_INJECT_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    localparam logic [19:0] A_CTRL = 20'h0, A_DATA = 20'h4, A_CW = 20'h8,
                            A_NOISE = 20'hC, A_STATUS = 20'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] data_out;
    logic        dout_valid, dout_ready;
    logic [1:0]  num_of_errors;
    logic        operation_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ecc_burst_codec dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .data_out(data_out), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .num_of_errors(num_of_errors),
        .operation_done(operation_done)
    );

    typedef struct {
        logic [1:0]  cw;
        logic [1:0]  ctrl;
        logic [31:0] noise;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(negedge clk);
        PENABLE = 1'b1;
        data = PRDATA;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        err;
        logic [31:0] rd;
        int          cnt;
        logic        seen_v, seen_d;
        logic [31:0] exp_q[$];

        //           cw     ctrl   noise         din           exp_data      exp_err                  exp_lat
        vecs[0]  = '{2'd0, 2'd0, 32'h0,        32'hB,        32'hAA,       2'd0,                    3};
        vecs[1]  = '{2'd0, 2'd0, 32'h0,        32'h1,        32'h0F,       2'd0,                    3};
        vecs[2]  = '{2'd0, 2'd0, 32'h0,        32'hF,        32'hFF,       2'd0,                    3};
        vecs[3]  = '{2'd3, 2'd0, 32'h0,        32'h1B,       32'hAA,       2'd0,                    3};
        vecs[4]  = '{2'd1, 2'd0, 32'h0,        32'h400,      32'h8117,     2'd0,                    3};
        vecs[5]  = '{2'd0, 2'd1, 32'h0,        32'hAC,       32'hB,        2'd2,                    3};
        vecs[6]  = '{2'd0, 2'd1, 32'h0,        32'hAE,       32'hB,        2'd1,                    3};
        vecs[7]  = '{2'd0, 2'd1, 32'h0,        32'hAB,       32'hB,        2'd1,                    3};
        vecs[8]  = '{2'd0, 2'd1, 32'h0,        32'h1AA,      32'hB,        2'd0,                    3};
        vecs[9]  = '{2'd1, 2'd1, 32'h0,        32'h8117,     32'h400,      2'd0,                    3};
        vecs[10] = '{2'd1, 2'd1, 32'h0,        32'h0117,     32'h400,      2'd1,                    3};
        vecs[11] = '{2'd0, 2'd2, 32'h08,       32'hB,        32'hB,        NOISE_ON ? 2'd1 : 2'd0, NOISE_ON ? 5 : 4};
        vecs[12] = '{2'd2, 2'd2, 32'h80000000, 32'h2ABCDEF,  32'h2ABCDEF,  NOISE_ON ? 2'd1 : 2'd0, NOISE_ON ? 5 : 4};
        vecs[13] = '{2'd2, 2'd3, 32'h3,        32'h3FFFFFF,  32'h3FFFFFF,  NOISE_ON ? 2'd2 : 2'd0, NOISE_ON ? 5 : 4};

        rst = 1'b1; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset dout_valid", {31'd0, dout_valid}, 32'd0);
        check("reset data_out", data_out, 32'd0);
        check("reset num_of_errors", {30'd0, num_of_errors}, 32'd0);
        check("reset operation_done", {31'd0, operation_done}, 32'd0);
        check("reset PRDATA", PRDATA, 32'd0);
        check("reset PSLVERR", {31'd0, PSLVERR}, 32'd0);
        check("PREADY tied", {31'd0, PREADY}, 32'd1);
        rst = 1'b0;
        apb_read(A_STATUS, rd);
        check("status after reset", rd, 32'd0);

        // Register readback.
        apb_write(A_CTRL, 32'h2, err);
        apb_read(A_CTRL, rd);
        check("ctrl readback", rd, 32'h2);
        apb_write(A_CW, 32'h3, err);
        apb_read(A_CW, rd);
        check("cw readback", rd, 32'h3);
        apb_write(A_NOISE, 32'h55, err);
        apb_read(A_NOISE, rd);
        check("noise readback", rd, NOISE_ON ? 32'h55 : 32'h0);
        apb_read(32'h14, rd);
        check("unmapped read", rd, 32'h0);

        // Table-driven single transactions.
        for (int i = 0; i < 14; i++) begin
            apb_write(A_CW, {30'd0, vecs[i].cw}, err);
            apb_write(A_CTRL, {30'd0, vecs[i].ctrl}, err);
            apb_write(A_NOISE, vecs[i].noise, err);
            apb_write(A_DATA, vecs[i].din, err);
            check($sformatf("v%0d pslverr", i), {31'd0, err}, 32'd0);
            cnt = 0;
            do begin
                @(posedge clk);
                #1 cnt++;
            end while (!dout_valid && cnt < 20);
            check($sformatf("v%0d latency", i), cnt, vecs[i].exp_lat);
            check($sformatf("v%0d data_out", i), data_out, vecs[i].exp_data);
            check($sformatf("v%0d num_of_errors", i), {30'd0, num_of_errors}, {30'd0, vecs[i].exp_err});
            check($sformatf("v%0d op_done early", i), {31'd0, operation_done}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d op_done pulse", i), {31'd0, operation_done}, 32'd1);
            check($sformatf("v%0d valid drop", i), {31'd0, dout_valid}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d op_done single", i), {31'd0, operation_done}, 32'd0);
        end

        // Overflow: stall one result in OUT, then fill the FIFO and overflow it.
        dout_ready = 1'b0;
        apb_write(A_CW, 32'h0, err);
        apb_write(A_CTRL, 32'h0, err);
        apb_write(A_DATA, 32'h1, err);
        for (int k = 2; k <= 6; k++) begin
            apb_write(A_DATA, k, err);
            check($sformatf("fill%0d pslverr", k), {31'd0, err}, (k == 6) ? 32'd1 : 32'd0);
        end
        check("stalled valid", {31'd0, dout_valid}, 32'd1);
        check("stalled data", data_out, 32'h0F);
        apb_read(A_STATUS, rd);
        check("status full+overflow", rd, 32'h184);

        // Release one result and land a write on the same edge as the pop.
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        apb_write(A_DATA, 32'h7, err);
        dout_ready = 1'b0;
        check("push on pop pslverr", {31'd0, err}, 32'd0);
        apb_read(A_STATUS, rd);
        check("status after push on pop", rd, 32'h184);
        apb_write(A_CTRL, 32'h80000000, err);
        apb_read(A_STATUS, rd);
        check("status overflow cleared", rd, 32'h84);

        exp_q = '{32'h33, 32'h3C, 32'h55, 32'h5A, 32'h69};
        dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cnt = 0;
            while (!dout_valid && cnt < 20) begin
                @(posedge clk);
                #1 cnt++;
            end
            check($sformatf("drain%0d timeout", k), {31'd0, dout_valid}, 32'd1);
            check($sformatf("drain%0d data", k), data_out, exp_q[k]);
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        apb_read(A_STATUS, rd);
        check("status drained", rd, 32'h0);

        // Reset mid-operation: the word must vanish without a result.
        apb_write(A_CTRL, 32'h2, err);
        apb_write(A_NOISE, 32'h08, err);
        apb_write(A_DATA, 32'hB, err);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
`ifdef ECC_NOISE_INJECT_EN
        @(posedge clk);
        #1;
`endif
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen_v = 1'b0;
        seen_d = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            seen_v = seen_v | dout_valid;
            seen_d = seen_d | operation_done;
        end
        check("reset abandon valid", {31'd0, seen_v}, 32'd0);
        check("reset abandon done", {31'd0, seen_d}, 32'd0);
        apb_read(A_STATUS, rd);
        check("status after mid reset", rd, 32'h0);
        apb_read(A_CTRL, rd);
        check("ctrl after mid reset", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
